// File: rtl/adler32_pkg.sv
// Shared definitions for the Adler-32 requester arbiter: FSM encoding,
// checksum constants and operand widths.
package adler32_pkg;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_SIZE   = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_STREAM = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_ABORT  = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = S_IDLE,
    ST_CLR    = S_CLR,
    ST_SIZE   = S_SIZE,
    ST_START  = S_START,
    ST_STREAM = S_STREAM,
    ST_WAIT   = S_WAIT,
    ST_ABORT  = S_ABORT,
    ST_DONE   = S_DONE
  } state_e;

  localparam int unsigned ADLER_MOD  = 65521;
  localparam logic [31:0] ADLER_INIT = 32'h0000_0001;
  localparam int          SIZE_W     = 32;

endpackage

// File: rtl/adler32_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic             any,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(ptr) + k) % N);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/adler32_arbiter.sv
// Round-robin scheduler sharing one Adler-32 engine among NUM_REQ requesters;
// sequences clear/size/start/stream/capture and aborts a job on byte underrun.
module adler32_arbiter
  import adler32_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [SIZE_W*NUM_REQ-1:0] req_size,
  input  logic [8*NUM_REQ-1:0]      req_data,
  input  logic [NUM_REQ-1:0]        req_dvalid,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        req_done,
  output logic                      req_err,
  output logic [31:0]               checksum,
  output logic                      eng_rst_n,
  output logic                      eng_size_valid,
  output logic                      eng_data_start,
  output logic [SIZE_W-1:0]         eng_size,
  output logic [7:0]                eng_data,
  input  logic                      eng_checksum_valid,
  input  logic [31:0]               eng_checksum
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e              state_q;
  logic [PTR_W-1:0]    g_q, ptr_q, ptr_d;
  logic [SIZE_W-1:0]   rem_q, rem_d;
  logic [31:0]         checksum_q;
  logic                err_q;

  logic                pickAny;
  logic [PTR_W-1:0]    pickIdx;
  logic [SIZE_W-1:0]   pickSize;
  logic [7:0]          laneData;
  logic                laneValid;
  logic [NUM_REQ-1:0]  grantVec;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req (req),
    .ptr (ptr_q),
    .any (pickAny),
    .idx (pickIdx)
  );

  // Lane muxing: the owner's byte stream and the candidate's job size.
  always_comb begin
    laneData  = '0;
    laneValid = 1'b0;
    pickSize  = '0;
    grantVec  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g_q == PTR_W'(i)) begin
        laneData    = req_data[i*8 +: 8];
        laneValid   = req_dvalid[i];
        grantVec[i] = 1'b1;
      end
      if (pickIdx == PTR_W'(i)) begin
        pickSize = req_size[i*SIZE_W +: SIZE_W];
      end
    end
  end

  assign rem_d = rem_q - SIZE_W'(1);
  assign ptr_d = (g_q == PTR_W'(NUM_REQ - 1)) ? '0 : g_q + PTR_W'(1);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      g_q        <= '0;
      ptr_q      <= '0;
      rem_q      <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pickAny) begin
            g_q        <= pickIdx;
            rem_q      <= pickSize;
            err_q      <= 1'b0;
            checksum_q <= '0;
            state_q    <= ST_CLR;
          end
        end
        ST_CLR:   state_q <= ST_SIZE;
        ST_SIZE:  state_q <= ST_START;
        ST_START: state_q <= (rem_q == '0) ? ST_WAIT : ST_STREAM;
        // The engine cannot stall, so a missing byte kills the job outright.
        ST_STREAM: begin
          if (laneValid) begin
            rem_q <= rem_d;
            if (rem_q == SIZE_W'(1)) state_q <= ST_WAIT;
          end else begin
            state_q <= ST_ABORT;
          end
        end
        ST_WAIT: begin
          if (eng_checksum_valid) begin
            checksum_q <= eng_checksum;
            state_q    <= ST_DONE;
          end
        end
        ST_ABORT: begin
          err_q      <= 1'b1;
          checksum_q <= '0;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          ptr_q   <= ptr_d;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant          = (state_q != ST_IDLE) ? grantVec : '0;
  assign req_ready      = (state_q == ST_STREAM && laneValid) ? grantVec : '0;
  assign req_done       = (state_q == ST_DONE) ? grantVec : '0;
  assign req_err        = (state_q == ST_DONE) && err_q;
  assign checksum       = (state_q == ST_DONE) ? checksum_q : '0;
  assign eng_rst_n      = !(rst || state_q == ST_CLR || state_q == ST_ABORT);
  assign eng_size_valid = (state_q == ST_SIZE);
  assign eng_size       = (state_q == ST_SIZE) ? rem_q : '0;
  assign eng_data_start = (state_q == ST_START);
  assign eng_data       = (state_q == ST_STREAM) ? laneData : '0;

endmodule

// File: doc/adler32_arbiter.md
# adler32_arbiter

Round-robin scheduler that shares one `adler32` checksum engine among `NUM_REQ` requesters. It owns the engine's control pins and performs the full per-job sequence: engine clear, size load, data start, byte streaming, and checksum capture. It sits between the requester ports and the single engine instance, and returns each checksum to the requester that issued the job. The engine cannot stall, so the block also detects byte underrun, aborts the job and flags it.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8)
- `clock`  in  1  system clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  NUM_REQ  job request per requester, held until `req_done`
- `req_size`  in  32*NUM_REQ  byte count per requester; stable while `req` is high
- `req_data`  in  8*NUM_REQ  byte per requester
- `req_dvalid`  in  NUM_REQ  byte valid per requester
- `grant`  out  NUM_REQ  one-hot owner of the engine, from CLR through DONE
- `req_ready`  out  NUM_REQ  byte consumed this cycle (granted lane only)
- `req_done`  out  NUM_REQ  one-cycle job-complete pulse
- `req_err`  out  1  valid with `req_done`: job aborted on underrun
- `checksum`  out  32  `{B,A}` result, valid with `req_done`; 0 when `req_err`=1
- `eng_rst_n`  out  1  engine synchronous reset, active-low
- `eng_size_valid`, `eng_data_start`  out  1  engine control pulses
- `eng_size`  out  32 / `eng_data` out 8  engine operands
- `eng_checksum_valid`  in  1 / `eng_checksum` in 32  engine result

## Operation
- States: IDLE, CLR, SIZE, START, STREAM, WAIT, ABORT, DONE.
- IDLE: if any `req` is high, pick the first set bit at or after `ptr`, wrapping modulo NUM_REQ. Latch index `g` and `req_size[g]` into `rem` (32-bit), then go to CLR. `req` is sampled only in IDLE; dropping `req` mid-job has no effect.
- CLR: `eng_rst_n`=0 for one cycle (restores engine A=1, B=0), then go to SIZE.
- SIZE: `eng_size_valid`=1 and `eng_size`=latched size, then go to START.
- START: `eng_data_start`=1. Go to STREAM if `rem`≠0, else to WAIT.
- STREAM: `eng_data`=`req_data[g]`.
  - If `req_dvalid[g]`=1: `req_ready[g]`=1 and `rem`--. When `rem` was 1, go to WAIT.
  - If `req_dvalid[g]`=0: go to ABORT. This is an underrun; no partial consumption.
- WAIT: on `eng_checksum_valid`, latch `eng_checksum` and go to DONE.
- ABORT: `eng_rst_n`=0 for one cycle, set the err flag, then go to DONE.
- DONE: `req_done[g]`=1, drive `checksum`/`req_err`, set `ptr`=(g+1) mod NUM_REQ, then go to IDLE.
- Outside CLR, ABORT and reset, `eng_rst_n`=1. `eng_data`=0 outside STREAM.
- A size of 0 is legal and yields checksum 0x00000001.

## Timing
- Job with size N granted at IDLE cycle t:
  - CLR at t+1, SIZE at t+2, START at t+3.
  - Bytes consumed at t+4..t+3+N.
  - Engine `checksum_valid` at t+4+N (WAIT).
  - `req_done` at t+5+N.
- Back-to-back jobs: the next grant decision is made in the IDLE cycle at t+6+N.
- Underrun at STREAM cycle k: ABORT at k+1, `req_done` with `req_err`=1 at k+2.
- Reset (also mid-job):
  - State returns to IDLE and `ptr`=0.
  - `grant`, `req_ready`, `req_done`, `req_err`, `checksum`, `eng_*` pulses and operands are all 0.
  - `eng_rst_n`=0 while `rst` is high.
  - A job cut by reset is dropped and gets no `req_done`.
- Simultaneous requests: only round-robin order decides; a requester is never granted twice while another is waiting.

## Structure
- Shared package `adler32_pkg`:
  - state encoding localparams;
  - `ADLER_MOD`=65521;
  - `ADLER_INIT`=32'h0000_0001;
  - `SIZE_W`=32.
- Sub-module `rr_arbiter`: combinational round-robin pick (inputs `req` and `ptr`; outputs `any` and `idx`).
- Top level: FSM, `rem` counter, lane muxing. The engine is instantiated outside this block.

## Test plan
- Req0 sends "abc" (size 3, dvalid held high) → `req_done[0]` at t+8, `checksum`=0x024D0127, `req_err`=0.
- Req2 sends "Wikipedia" (size 9) → `checksum`=0x11E60398. The engine is cleared before the job even after a prior job.
- Req1 sends size 0 → `req_done[1]` at t+5, `checksum`=0x00000001.
- `req`=4'b1111 with all sizes 1, `ptr`=0 → grant order 0,1,2,3,0. Each `req_done` arrives 6 cycles after its grant.
- Req3 sends size 4 and drops `req_dvalid` on byte 2 → ABORT, `req_err`=1, `checksum`=0. The next job, "abc", still gives 0x024D0127.
- `rst` pulsed during STREAM → all outputs 0 immediately and no `req_done`. A subsequent "abc" job gives the correct checksum.
